mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that shares the 4:1 structural multiplexer between four requesters. Each requester raises a request; the arbiter grants one at a time, drives the mux select lines (`address0`, `address1`) to that requester's input, and holds the grant until the request drops or a hold limit expires. It sits directly in front of `structuralMultiplexer` and is the only driver of its address pins.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one owner may hold the grant; legal range 1..255.
- `clk`  in  1  single clock, rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  request per requester; bit i targets mux input `in<i>`.
- `enable`  in  1  when 0, no new grant is issued; the current grant runs to its normal release.
- `grant`  out  4  registered one-hot grant, all zero when idle.
- `address0`  out  1  mux select LSB; `grant[1]` or `grant[3]`.
- `address1`  out  1  mux select MSB; `grant[2]` or `grant[3]`.
- `valid`  out  1  1 while any grant is held, meaning mux `out` carries the owner's data.
- `hold_cnt`  out  8  cycles the current owner has held the grant, minus one; 0 when idle.

## Operation
- Select encoding: `{address1,address0}` = 00 selects in0, 01 selects in1, 10 selects in2, 11 selects in3. When idle, `address0`=`address1`=0.
- Rotating pointer `ptr` (2 bits) marks the highest-priority requester. The winner is the first i with `req[i]`=1, scanning ptr, ptr+1, … mod 4.
- States:
  - IDLE: `grant`=0. At an edge where `enable`=1 and `req`≠0, go to BUSY. Set `grant` one-hot for the winner, set `hold_cnt`=0, and set address bits.
  - BUSY: at each edge, release if `req[owner]`=0 or `hold_cnt`=MAX_HOLD-1. Otherwise increment `hold_cnt`.
  - On release, `ptr` becomes owner+1 mod 4. If `enable`=1 and another winner exists under the new `ptr` (the old owner is eligible last), grant it on the same edge (back-to-back, no idle cycle) with `hold_cnt`=0. If there is no winner, go to IDLE.
- A timed-out owner whose request is still high regains the grant only if no other requester is pending.
- `enable`=0 never revokes a held grant. It only blocks new or next grants, so a release while `enable`=0 goes to IDLE.
- `req` changes of non-owners while in BUSY have no effect until release.
- `grant`, `address0`, `address1`, `valid` and `hold_cnt` are all registered and change only at rising `clk` or on reset.

## Timing
- Reset (`reset_n`=0, asynchronous): `grant`=0000, `address0`=`address1`=0, `valid`=0, `hold_cnt`=0, `ptr`=0, state IDLE. This holds for the whole time reset is low.
- Reset asserted mid-grant: all outputs clear immediately, without waiting for a clock edge.
- After `reset_n` rises, the first grant can appear at the first rising edge that samples a request.
- Grant latency: a request sampled at edge k gives `grant`/`valid`/address valid after edge k, one cycle, from IDLE.
- Release latency: a request dropped before edge k gives `grant` changes at edge k.
- Maximum tenure: exactly MAX_HOLD cycles with `valid`=1 per grant. When MAX_HOLD=1, the grant rotates every cycle among the active requesters.
- Wrap-around: the pointer goes from 3 to 0. `hold_cnt` never exceeds MAX_HOLD-1.
- Simultaneous release and new request on the same edge: the new request takes part in that edge's pick.

## Structure
- Package `mux_arb_pkg`:
  - `NUM_REQ`=4.
  - `SEL_W`=2.
  - State enum {IDLE, BUSY}.
  - Function mapping a one-hot grant to the `{address1,address0}` pair.
- Sub-module `rr_pick`: combinational, with inputs `req[3:0]` and `ptr[1:0]`, and outputs winner one-hot and `any`. It is used for both the IDLE pick and the BUSY-release pick.
- Top level: state register, pointer, hold counter and output registers. The arbiter is instantiated alongside `structuralMultiplexer` in the bench, with `address0`/`address1` wired through.

## Test plan
- Reset and single request: reset, then `req`=0100 for 3 cycles, then 0000. Required: after the first edge `grant`=0100, `{address1,address0}`=10, `valid`=1, and mux `out`=`in2`. One edge after the request drops, `grant`=0000 and `valid`=0.
- Round-robin fairness: `req`=1111 held, MAX_HOLD=2. Required: grant sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001…, with no idle cycles between grants.
- Timeout re-grant: only `req[3]` high for 10 cycles, MAX_HOLD=4. Required: `hold_cnt` runs 0,1,2,3,0,1,… and `grant` stays 1000 throughout.
- Enable gating: grant held on requester 1, `enable` driven to 0, requester 1 drops its request while `req[2]`=1. Required: go to IDLE with `grant`=0000. When `enable` returns to 1, `grant`=0100 one edge later.
- Asynchronous reset mid-grant: `reset_n` pulled low between edges while `grant`=0010. Required: all outputs are 0 before the next edge, and after release the pointer restarts at 0, so `req`=1111 grants 0001 first.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants, FSM state type and grant-to-select mapping
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {IDLE, BUSY} state_t;

  // One-hot grant to {address1,address0}; an all-zero grant maps to 00.
  function automatic logic [SEL_W-1:0] grant_to_sel(input logic [NUM_REQ-1:0] g);
    logic [SEL_W-1:0] sel;
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g[i]) sel = sel | SEL_W'(i);
    end
    return sel;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - request/grant bundle between requesters and the arbiter
interface mux_rr_arbiter_if;
  import mux_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               enable;
  logic [NUM_REQ-1:0] grant;
  logic               address0;
  logic               address1;
  logic               valid;
  logic [7:0]         hold_cnt;

  modport master (
    input  req, enable,
    output grant, address0, address1, valid, hold_cnt
  );

  modport slave (
    output req, enable,
    input  grant, address0, address1, valid, hold_cnt
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner search starting at ptr
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               any
);

  // Scan from the farthest slot back to ptr so the nearest request wins last.
  always_comb begin
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[ptr + SEL_W'(k)]) winner = NUM_REQ'(1) << (ptr + SEL_W'(k));
    end
  end

  assign any = |req;

endmodule

// File: rtl/structuralMultiplexer.sv
// rtl/structuralMultiplexer.sv - 4:1 mux built from decoded AND-OR terms
module structuralMultiplexer #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             address0,
  input  logic             address1,
  output logic [WIDTH-1:0] out
);

  logic s0, s1, s2, s3;

  assign s0 = ~address1 & ~address0;
  assign s1 = ~address1 &  address0;
  assign s2 =  address1 & ~address0;
  assign s3 =  address1 &  address0;

  assign out = (in0 & {WIDTH{s0}}) | (in1 & {WIDTH{s1}})
             | (in2 & {WIDTH{s2}}) | (in3 & {WIDTH{s3}});

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin owner of the 4:1 mux select lines with hold limit
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input logic              clk,
  input logic              reset_n,
  mux_rr_arbiter_if.master bus
);

  state_t             state, state_nx;
  logic [SEL_W-1:0]   ptr, ptr_nx, owner, pick_ptr, sel_q;
  logic [NUM_REQ-1:0] grant_q, grant_nx, winner;
  logic [7:0]         hold_q, hold_nx;
  logic               valid_q, any, expire;

  assign owner    = grant_to_sel(grant_q);
  // On release the search already starts past the owner, so the owner is considered last.
  assign pick_ptr = (state == BUSY) ? owner + SEL_W'(1) : ptr;
  assign expire   = !bus.req[owner] || (hold_q == 8'(MAX_HOLD - 1));

  rr_pick u_pick (
    .req    (bus.req),
    .ptr    (pick_ptr),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    grant_nx = grant_q;
    hold_nx  = hold_q;
    case (state)
      IDLE: begin
        if (bus.enable && any) begin
          state_nx = BUSY;
          grant_nx = winner;
          hold_nx  = '0;
        end
      end
      BUSY: begin
        if (expire) begin
          ptr_nx  = owner + SEL_W'(1);
          hold_nx = '0;
          if (bus.enable && any) begin
            grant_nx = winner;
          end else begin
            state_nx = IDLE;
            grant_nx = '0;
          end
        end else begin
          hold_nx = hold_q + 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
        hold_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ptr     <= '0;
      grant_q <= '0;
      hold_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      grant_q <= grant_nx;
      hold_q  <= hold_nx;
      sel_q   <= grant_to_sel(grant_nx);
      valid_q <= |grant_nx;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.address0 = sel_q[0];
  assign bus.address1 = sel_q[1];
  assign bus.valid    = valid_q;
  assign bus.hold_cnt = hold_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - randomized and directed checks of three arbiter instances
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       enable = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00, d2 = 8'h00, d3 = 8'h00;
  logic [7:0] mux_out;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter_if bus1 ();
  mux_rr_arbiter_if bus2 ();
  mux_rr_arbiter_if bus4 ();

  assign bus1.req = req;
  assign bus2.req = req;
  assign bus4.req = req;
  assign bus1.enable = enable;
  assign bus2.enable = enable;
  assign bus4.enable = enable;

  mux_rr_arbiter #(.MAX_HOLD(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
  mux_rr_arbiter #(.MAX_HOLD(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));
  mux_rr_arbiter #(.MAX_HOLD(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));

  structuralMultiplexer #(.WIDTH(8)) u_mux (
    .in0(d0), .in1(d1), .in2(d2), .in3(d3),
    .address0(bus4.address0), .address1(bus4.address1),
    .out(mux_out)
  );

  logic [3:0] g_obs [3];
  logic [1:0] a_obs [3];
  logic       v_obs [3];
  logic [7:0] h_obs [3];

  assign g_obs[0] = bus1.grant;  assign a_obs[0] = {bus1.address1, bus1.address0};
  assign g_obs[1] = bus2.grant;  assign a_obs[1] = {bus2.address1, bus2.address0};
  assign g_obs[2] = bus4.grant;  assign a_obs[2] = {bus4.address1, bus4.address0};
  assign v_obs[0] = bus1.valid;  assign h_obs[0] = bus1.hold_cnt;
  assign v_obs[1] = bus2.valid;  assign h_obs[1] = bus2.hold_cnt;
  assign v_obs[2] = bus4.valid;  assign h_obs[2] = bus4.hold_cnt;

  // Reference: owner index (-1 idle), tenure count and pointer per instance.
  int mh [3]     = '{1, 2, 4};
  int m_own [3]  = '{-1, -1, -1};
  int m_hc [3]   = '{0, 0, 0};
  int m_ptr [3]  = '{0, 0, 0};

  function automatic int pick(logic [3:0] r, int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] mgrant(int o);
    return (o < 0) ? 4'b0000 : 4'(1 << o);
  endfunction

  function automatic logic [1:0] maddr(int o);
    return (o < 0) ? 2'b00 : 2'(o);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    for (int j = 0; j < 3; j++) begin
      if (!reset_n) begin
        m_own[j] = -1; m_hc[j] = 0; m_ptr[j] = 0;
      end else if (m_own[j] < 0) begin
        if (enable && req != 4'b0000) begin
          m_own[j] = pick(req, m_ptr[j]);
          m_hc[j]  = 0;
        end
      end else if (!req[m_own[j]] || m_hc[j] == mh[j] - 1) begin
        m_ptr[j] = (m_own[j] + 1) % 4;
        m_own[j] = enable ? pick(req, m_ptr[j]) : -1;
        m_hc[j]  = 0;
      end else begin
        m_hc[j] = m_hc[j] + 1;
      end
    end
  end

  task automatic apply_reset();
    reset_n = 1'b0; req = 4'b0000; enable = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 4'b1111; enable = 1'b1;
    repeat (2) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      checks++;
      if ({g_obs[j], a_obs[j], v_obs[j], h_obs[j]} !== 15'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got g=%b a=%b v=%b h=%0d want all zero",
                 j, g_obs[j], a_obs[j], v_obs[j], h_obs[j]);
      end
    end
  endtask

  task automatic test_single();
    apply_reset();
    d2 = 8'($urandom); d0 = d2 ^ 8'h5A; d1 = d2 ^ 8'hA5; d3 = d2 ^ 8'hFF;
    req = 4'b0100;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (g_obs[j] !== 4'b0100 || a_obs[j] !== 2'b10 || v_obs[j] !== 1'b1 || h_obs[j] !== 8'd0) begin
        errors++;
        $display("FAIL single_grant dut%0d got g=%b a=%b v=%b h=%0d want 0100 10 1 0",
                 j, g_obs[j], a_obs[j], v_obs[j], h_obs[j]);
      end
    end
    checks++;
    if (mux_out !== d2) begin
      errors++;
      $display("FAIL single_mux_out got %h want %h", mux_out, d2);
    end
    repeat (2) @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (g_obs[j] !== 4'b0000 || v_obs[j] !== 1'b0) begin
        errors++;
        $display("FAIL single_release dut%0d got g=%b v=%b want 0000 0", j, g_obs[j], v_obs[j]);
      end
    end
  endtask

  task automatic test_fairness();
    apply_reset();
    req = 4'b1111;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      checks++;
      if (g_obs[1] !== 4'(1 << ((n / 2) % 4)) || v_obs[1] !== 1'b1) begin
        errors++;
        $display("FAIL fairness_hold2 step%0d got g=%b v=%b want %b 1",
                 n, g_obs[1], v_obs[1], 4'(1 << ((n / 2) % 4)));
      end
      checks++;
      if (g_obs[0] !== 4'(1 << (n % 4))) begin
        errors++;
        $display("FAIL fairness_hold1 step%0d got g=%b want %b", n, g_obs[0], 4'(1 << (n % 4)));
      end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    req = 4'b1000;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      checks++;
      if (h_obs[2] !== 8'(n % 4) || g_obs[2] !== 4'b1000) begin
        errors++;
        $display("FAIL timeout_regrant step%0d got h=%0d g=%b want %0d 1000",
                 n, h_obs[2], g_obs[2], n % 4);
      end
    end
  endtask

  task automatic test_enable();
    apply_reset();
    req = 4'b0010;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (g_obs[j] !== 4'b0010) begin
        errors++;
        $display("FAIL enable_initial dut%0d got %b want 0010", j, g_obs[j]);
      end
    end
    enable = 1'b0; req = 4'b0110;
    @(negedge clk);
    req = 4'b0100;
    repeat (2) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (g_obs[j] !== 4'b0000 || v_obs[j] !== 1'b0) begin
        errors++;
        $display("FAIL enable_blocked dut%0d got g=%b v=%b want 0000 0", j, g_obs[j], v_obs[j]);
      end
    end
    enable = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (g_obs[j] !== 4'b0100) begin
        errors++;
        $display("FAIL enable_resume dut%0d got %b want 0100", j, g_obs[j]);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req = 4'b0010;
    @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if ({g_obs[j], a_obs[j], v_obs[j], h_obs[j]} !== 15'd0) begin
        errors++;
        $display("FAIL async_reset dut%0d got g=%b a=%b v=%b h=%0d want all zero",
                 j, g_obs[j], a_obs[j], v_obs[j], h_obs[j]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1; req = 4'b1111;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (g_obs[j] !== 4'b0001) begin
        errors++;
        $display("FAIL async_restart dut%0d got %b want 0001", j, g_obs[j]);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (g_obs[j] !== mgrant(m_own[j]) || a_obs[j] !== maddr(m_own[j]) ||
            v_obs[j] !== (m_own[j] >= 0) || h_obs[j] !== 8'(m_hc[j])) begin
          errors++;
          $display("FAIL random_model cyc%0d dut%0d got g=%b a=%b v=%b h=%0d want %b %b %b %0d",
                   n, j, g_obs[j], a_obs[j], v_obs[j], h_obs[j],
                   mgrant(m_own[j]), maddr(m_own[j]), m_own[j] >= 0, m_hc[j]);
        end
      end
      if (m_own[2] >= 0) begin
        checks++;
        if (mux_out !== ((m_own[2] == 0) ? d0 : (m_own[2] == 1) ? d1 : (m_own[2] == 2) ? d2 : d3)) begin
          errors++;
          $display("FAIL random_mux cyc%0d got %h owner %0d", n, mux_out, m_own[2]);
        end
      end
      req     = 4'($urandom);
      enable  = ($urandom_range(0, 7) != 0);
      reset_n = ($urandom_range(0, 59) != 0);
      d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom); d3 = 8'($urandom);
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_enable();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
